// File: rtl/cordic_seq_ctrl_if.sv
// Handshake bundle between the CORDIC datapath/sign detector and its
// sequencing controller.
interface cordic_seq_ctrl_if;
    logic       start;
    logic       mode;
    logic       abort;
    logic       sd_valid;
    logic       sd_sgn;
    logic       busy;
    logic       load_en;
    logic       sd_req;
    logic       rot_en;
    logic       rot_dir;
    logic [3:0] iter_idx;
    logic       done;
    logic       err;

    modport master (
        output start, mode, abort, sd_valid, sd_sgn,
        input  busy, load_en, sd_req, rot_en, rot_dir,
        input  iter_idx, done, err
    );

    modport slave (
        input  start, mode, abort, sd_valid, sd_sgn,
        output busy, load_en, sd_req, rot_en, rot_dir,
        output iter_idx, done, err
    );
endinterface

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for an iterative carry-save CORDIC: load, then per iteration
// ask the sign detector, wait for it, and issue one micro-rotation.
module cordic_seq_ctrl #(
    parameter int N_ITER  = 16,
    parameter int TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             reset,
    cordic_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SIGN,
        S_WAIT,
        S_ROTATE,
        S_DONE
    } state_e;

    localparam logic [3:0] ITER_LAST = 4'(N_ITER - 1);
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] iter_q, iter_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic       mode_q, mode_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            wcnt_q  <= '0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            wcnt_q  <= wcnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        wcnt_d  = wcnt_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = S_LOAD;
                    mode_d  = bus.mode;
                    err_d   = 1'b0;
                    iter_d  = '0;
                end
            end
            S_LOAD: state_d = S_SIGN;
            S_SIGN: begin
                state_d = S_WAIT;
                wcnt_d  = '0;
            end
            S_WAIT: begin
                // Vectoring drives Y to zero, rotation drives Z to zero
                if (bus.sd_valid) begin
                    state_d = S_ROTATE;
                    dir_d   = mode_q ? bus.sd_sgn : ~bus.sd_sgn;
                end else if (wcnt_q == WAIT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            S_ROTATE: begin
                if (iter_q == ITER_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SIGN;
                    iter_d  = iter_q + 4'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything and leaves the bookkeeping untouched
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            iter_d  = iter_q;
            wcnt_d  = wcnt_q;
            mode_d  = mode_q;
            dir_d   = dir_q;
            err_d   = err_q;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.load_en  = (state_q == S_LOAD);
    assign bus.sd_req   = (state_q == S_SIGN);
    assign bus.rot_en   = (state_q == S_ROTATE);
    assign bus.rot_dir  = (state_q == S_ROTATE) & dir_q;
    assign bus.iter_idx = iter_q;
    assign bus.done     = (state_q == S_DONE);
    assign bus.err      = err_q;

endmodule

// File: doc/cordic_seq_ctrl.md
CORDIC_SEQ_CTRL -- requirements
Module: cordic_seq_ctrl

Interface
REQ-001 Parameter: N_ITER, 16, number of CORDIC micro-rotations per operation (range 2..16).
REQ-002 Parameter: TIMEOUT, 4, maximum WAIT cycles without sd_valid before error (range 1..15).
REQ-003 Port: clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: start  input  1  request a new operation; sampled only in IDLE.
REQ-006 Port: mode  input  1  0 = rotation (steer on Z sign), 1 = vectoring (steer on Y sign); captured at accepted start.
REQ-007 Port: abort  input  1  cancel the operation in progress.
REQ-008 Port: sd_valid  input  1  sign-detector result strobe (detector data_out).
REQ-009 Port: sd_sgn  input  1  sign-detector result, 1 = negative.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: load_en  output  1  one-cycle pulse loading X/Y/Z carry-save registers.
REQ-012 Port: sd_req  output  1  one-cycle pulse driving the sign detector data_in.
REQ-013 Port: rot_en  output  1  one-cycle pulse enabling one micro-rotation.
REQ-014 Port: rot_dir  output  1  rotation direction, 1 = +sigma, 0 = -sigma; valid when rot_en=1.
REQ-015 Port: iter_idx  output  4  current iteration, shift amount and arctan-table index.
REQ-016 Port: done  output  1  one-cycle completion pulse.
REQ-017 Port: err  output  1  sticky timeout flag.

Function
REQ-018 States SHALL be IDLE, LOAD, SIGN, WAIT, ROTATE, DONE, all Moore-decoded from registered state.
REQ-019 IDLE: start=1 and abort=0 -> LOAD; mode captured, err cleared, iter_idx cleared to 0.
REQ-020 LOAD: load_en=1 for exactly one cycle, then SIGN.
REQ-021 SIGN: sd_req=1 for exactly one cycle, then WAIT; sd_valid in SIGN SHALL be ignored.
REQ-022 WAIT: sd_valid=1 -> captured direction = sd_sgn if mode=1 else ~sd_sgn, then ROTATE; wait counter cleared on WAIT entry.
REQ-023 WAIT: TIMEOUT consecutive WAIT cycles with sd_valid=0 -> err set to 1, next state DONE, no rot_en issued.
REQ-024 ROTATE: rot_en=1 one cycle, rot_dir = captured direction; if iter_idx = N_ITER-1 then DONE, else iter_idx+1 and SIGN.
REQ-025 iter_idx SHALL hold its value from SIGN through ROTATE of the same iteration and never exceed N_ITER-1 (no wrap).
REQ-026 DONE: done=1 one cycle, then IDLE; iter_idx keeps its final value.
REQ-027 Minimum latency: with sd_valid on the first WAIT cycle, done SHALL assert 2+3*N_ITER cycles after the edge accepting start (50 for N_ITER=16).
REQ-028 abort=1 in any non-IDLE state -> IDLE on next edge, no done pulse, err unchanged, all pulses deasserted.
REQ-029 abort wins over simultaneous sd_valid, timeout or start; start while busy SHALL be ignored (not queued).
REQ-030 load_en, sd_req, rot_en, done SHALL be mutually exclusive in every cycle.

Reset
REQ-031 reset=1 SHALL force IDLE, iter_idx=0, captured mode=0, wait counter=0, and busy, load_en, sd_req, rot_en, rot_dir, done, err all 0, asynchronously.
REQ-032 reset asserted mid-operation SHALL abandon it with no done pulse; first start after release SHALL begin a fresh operation.

Verification
REQ-033 Rotation, N_ITER=16, sd_valid one cycle after each sd_req, sd_sgn alternating 0,1 -> 16 rot_en pulses, rot_dir 1,0,1,..., iter_idx 0..15, done 50 cycles after start.
REQ-034 Vectoring, sd_sgn=1 constant, sd_valid delayed 2 WAIT cycles -> all rot_dir=1, done at 2+4*16=66 cycles, err=0.
REQ-035 sd_valid withheld at iteration 5, TIMEOUT=4 -> 5 rot_en pulses, err=1 after 4 WAIT cycles, done next cycle, err cleared by next accepted start.
REQ-036 abort during WAIT of iteration 3 with sd_valid=1 same cycle -> no rot_en, IDLE next cycle, busy=0, no done.
REQ-037 start held high throughout an operation -> single operation, no restart until IDLE, then new LOAD one cycle after IDLE.
REQ-038 reset pulsed mid-ROTATE -> all outputs 0 immediately, iter_idx=0; subsequent operation completes normally.
